// File: rtl/sdram_cas_rsp_pkg.sv
// Shared types and helpers for the SDRAM CAS/DQ responder.
// Optional error reporting is enabled by defining SDRAM_CAS_RSP_ERR_EN.
package sdram_cas_rsp_pkg;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_READ  = 2'd1,
      CMD_WRITE = 2'd2,
      CMD_OTHER = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } st_e;

   localparam int CL_MIN     = 1;
   localparam int CL_MAX     = 3;
   localparam int CL_DEFAULT = 3;

   // {ras_n,cas_n,we_n}: 101 read, 100 write, 111 nop, anything else is ignored.
   function automatic cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
      case ({ras_n, cas_n, we_n})
         3'b101:  return CMD_READ;
         3'b100:  return CMD_WRITE;
         3'b111:  return CMD_NOP;
         default: return CMD_OTHER;
      endcase
   endfunction

   function automatic logic cl_illegal(input logic [2:0] cfg);
      return (cfg < 3'(CL_MIN)) || (cfg > 3'(CL_MAX));
   endfunction

   // Out-of-range latencies fall back to the slowest legal value.
   function automatic logic [1:0] legal_cl(input logic [2:0] cfg);
      if (cl_illegal(cfg)) return 2'(CL_DEFAULT);
      return cfg[1:0];
   endfunction

endpackage

// File: rtl/sdram_cas_rsp_if.sv
// Command/data bus between an SDRAM controller (master) and the responder (slave).
// Optional error reporting is enabled by defining SDRAM_CAS_RSP_ERR_EN.
//
// Protocol: there is no backpressure. A command {ras_n,cas_n,we_n} with col is
// taken at every rising edge; write beats are taken from dq_in at the command
// edge and the following edges. Read data is valid exactly when dq_oe (== stb)
// is high, one beat per cycle; the master must always accept it.
interface sdram_cas_rsp_if #(
   parameter int DQ_WIDTH  = 16,
   parameter int COL_WIDTH = 8
);
   import sdram_cas_rsp_pkg::*;

   logic                 ras_n;
   logic                 cas_n;
   logic                 we_n;
   logic [COL_WIDTH-1:0] col;
   logic [DQ_WIDTH-1:0]  dq_in;
   logic [DQ_WIDTH-1:0]  dq_out;
   logic                 dq_oe;
   logic                 stb;
   st_e                  dbg_state;

   modport master (
      output ras_n, cas_n, we_n, col, dq_in,
      input  dq_out, dq_oe, stb, dbg_state
   );

   modport slave (
      input  ras_n, cas_n, we_n, col, dq_in,
      output dq_out, dq_oe, stb, dbg_state
   );

endinterface

// File: rtl/sdram_cas_rsp_rdpipe.sv
// CAS-latency delay line for read beats: three {valid,data} stages, output tap
// chosen by the latched latency. Beats never advance past the tap stage, so a
// later increase of latency cannot resurrect beats that were already delivered.
module sdram_cas_rsp_rdpipe
   import sdram_cas_rsp_pkg::*;
#(
   parameter int DQ_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          i_cl,
   input  logic                i_flush,
   input  logic                i_push,
   input  logic [DQ_WIDTH-1:0] i_data,
   output logic                o_valid,
   output logic [DQ_WIDTH-1:0] o_data,
   output logic                o_busy
);

   logic [2:0]          r_vld;
   logic [DQ_WIDTH-1:0] r_dat [3];

   // Valid bits shift toward the tap; a flush drops everything in flight,
   // while a beat pushed on the same edge still enters stage 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_push;
         r_vld[1] <= r_vld[0] && !i_flush && (i_cl >= 2'd2);
         r_vld[2] <= r_vld[1] && !i_flush && (i_cl == 2'd3);
      end
   end

   // Data stages carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      r_dat[0] <= i_data;
      r_dat[1] <= r_dat[0];
      r_dat[2] <= r_dat[1];
   end

   // Output tap by latency: CL1 -> stage 0, CL2 -> stage 1, CL3 -> stage 2.
   always_comb begin
      o_valid = r_vld[2];
      o_data  = r_dat[2];
      case (i_cl)
         2'd1: begin o_valid = r_vld[0]; o_data = r_dat[0]; end
         2'd2: begin o_valid = r_vld[1]; o_data = r_dat[1]; end
         default: ;
      endcase
   end

   assign o_busy = |r_vld;

endmodule

// File: rtl/sdram_cas_rsp.sv
// SDRAM CAS/DQ responder: decodes READ/WRITE, runs sequential-wrap bursts over a
// column array and returns read data after the latched CAS latency.
// Define SDRAM_CAS_RSP_ERR_EN to add the err pulse and saturating err_cnt outputs.
module sdram_cas_rsp
   import sdram_cas_rsp_pkg::*;
#(
   parameter int DQ_WIDTH  = 16,
   parameter int COL_WIDTH = 8,
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] cfg_sdr_cas,
`ifdef SDRAM_CAS_RSP_ERR_EN
   output logic       err,
   output logic [7:0] err_cnt,
`endif
   sdram_cas_rsp_if.slave bus
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [COL_WIDTH-1:0] LOW_MASK = COL_WIDTH'(BURST_LEN - 1);

   cmd_e                 w_cmd;
   logic                 w_is_rd;
   logic                 w_is_wr;
   logic [1:0]           w_cl_cfg;
   logic [BW-1:0]        w_next_beat;
   logic [COL_WIDTH-1:0] w_seq_addr;
   logic [COL_WIDTH-1:0] w_addr;
   logic                 w_issue_rd;
   logic                 w_issue_wr;
   logic [DQ_WIDTH-1:0]  w_rd_data;
   logic                 w_pipe_busy;
   logic                 w_flush;
   logic                 w_tap_vld;
   logic [DQ_WIDTH-1:0]  w_tap_data;

   st_e                  r_state;
   logic [BW-1:0]        r_beat;
   logic [COL_WIDTH-1:0] r_col;
   logic [1:0]           r_cl;
   logic [DQ_WIDTH-1:0]  r_dq_out;
   logic                 r_oe;
   logic [DQ_WIDTH-1:0]  r_mem [2**COL_WIDTH];

   assign w_cmd    = decode_cmd(bus.ras_n, bus.cas_n, bus.we_n);
   assign w_is_rd  = (w_cmd == CMD_READ);
   assign w_is_wr  = (w_cmd == CMD_WRITE);
   assign w_cl_cfg = legal_cl(cfg_sdr_cas);

   // Next beat of the running burst: high column bits fixed, low bits wrap.
   assign w_next_beat = r_beat + BW'(1);
   assign w_seq_addr  = (r_col & ~LOW_MASK) | ((r_col + COL_WIDTH'(w_next_beat)) & LOW_MASK);

   // Pick this edge's array access: a new command always wins over a running burst.
   always_comb begin
      w_issue_rd = 1'b0;
      w_issue_wr = 1'b0;
      w_addr     = w_seq_addr;
      if (w_is_rd) begin
         w_issue_rd = 1'b1;
         w_addr     = bus.col;
      end else if (w_is_wr) begin
         w_issue_wr = 1'b1;
         w_addr     = bus.col;
      end else if (r_state == ST_RD_BURST) begin
         w_issue_rd = 1'b1;
      end else if (r_state == ST_WR_BURST) begin
         w_issue_wr = 1'b1;
      end
   end

   // A write must not collide with read data still heading for the bus, and
   // beats timed for one latency must not mix with beats timed for another.
   assign w_flush = (w_is_wr && w_pipe_busy) ||
                    (w_is_rd && w_pipe_busy && (w_cl_cfg != r_cl));

   // Burst FSM: state means "more beats remain to issue after this one".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
         r_col   <= '0;
         r_cl    <= 2'(CL_DEFAULT);
      end else if (w_is_rd || w_is_wr) begin
         r_col  <= bus.col;
         r_beat <= '0;
         if (BURST_LEN == 1) r_state <= ST_IDLE;
         else                r_state <= w_is_rd ? ST_RD_BURST : ST_WR_BURST;
         if (w_is_rd) r_cl <= w_cl_cfg;
      end else if (r_state != ST_IDLE) begin
         r_beat <= w_next_beat;
         if (w_next_beat == BW'(BURST_LEN - 1)) r_state <= ST_IDLE;
      end
   end

   // Column array write port; the read port below sees the pre-edge contents.
   always_ff @(posedge clk) begin
      if (w_issue_wr) r_mem[w_addr] <= bus.dq_in;
   end

   assign w_rd_data = r_mem[w_addr];

   sdram_cas_rsp_rdpipe #(
      .DQ_WIDTH (DQ_WIDTH)
   ) u_rdpipe (
      .clk     (clk),
      .reset_n (reset_n),
      .i_cl    (r_cl),
      .i_flush (w_flush),
      .i_push  (w_issue_rd),
      .i_data  (w_rd_data),
      .o_valid (w_tap_vld),
      .o_data  (w_tap_data),
      .o_busy  (w_pipe_busy)
   );

   // Registered bus drive; a flush releases the bus at the flushing edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oe     <= 1'b0;
         r_dq_out <= '0;
      end else if (w_flush) begin
         r_oe     <= 1'b0;
         r_dq_out <= '0;
      end else begin
         r_oe     <= w_tap_vld;
         r_dq_out <= w_tap_vld ? w_tap_data : '0;
      end
   end

   assign bus.dq_out    = r_dq_out;
   assign bus.dq_oe     = r_oe;
   assign bus.stb       = r_oe;
   assign bus.dbg_state = r_state;

`ifdef SDRAM_CAS_RSP_ERR_EN
   logic       w_err_evt;
   logic       r_err;
   logic [7:0] r_err_cnt;

   assign w_err_evt = (w_is_rd && cl_illegal(cfg_sdr_cas)) || w_flush;

   // One pulse and one count per offending edge, even with several causes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_err_evt;
         if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err     = r_err;
   assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sdram_cas_rsp.sv
// Directed bench for sdram_cas_rsp; builds with or without SDRAM_CAS_RSP_ERR_EN.
module tb_sdram_cas_rsp;
   import sdram_cas_rsp_pkg::*;

   localparam int DQ_WIDTH  = 16;
   localparam int COL_WIDTH = 8;
   localparam int BURST_LEN = 4;

   localparam logic [2:0] C_NOP = 3'b111;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_WR  = 3'b100;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] cfg_sdr_cas = 3'd2;
   int         n_pass = 0;
   int         n_total = 0;

   sdram_cas_rsp_if #(.DQ_WIDTH(DQ_WIDTH), .COL_WIDTH(COL_WIDTH)) bus ();

`ifdef SDRAM_CAS_RSP_ERR_EN
   logic       err;
   logic [7:0] err_cnt;
`endif

   sdram_cas_rsp #(
      .DQ_WIDTH  (DQ_WIDTH),
      .COL_WIDTH (COL_WIDTH),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cfg_sdr_cas (cfg_sdr_cas),
`ifdef SDRAM_CAS_RSP_ERR_EN
      .err         (err),
      .err_cnt     (err_cnt),
`endif
      .bus         (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drv_cmd(input logic [2:0] c, input logic [7:0] col_v, input logic [15:0] d);
      {bus.ras_n, bus.cas_n, bus.we_n} = c;
      bus.col   = col_v;
      bus.dq_in = d;
   endtask

   task automatic do_reset();
      drv_cmd(C_NOP, 8'h00, 16'h0);
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic write_burst(input logic [7:0] c, input logic [15:0] base);
      for (int i = 0; i < BURST_LEN; i++) begin
         drv_cmd((i == 0) ? C_WR : C_NOP, c, base + 16'(i));
         step();
      end
      drv_cmd(C_NOP, 8'h00, 16'h0);
      step();
   endtask

   task automatic idle(input int n);
      drv_cmd(C_NOP, 8'h00, 16'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drv_cmd(C_NOP, 8'h00, 16'h0);
      reset_n = 1'b0;
      step();
      step();
      n_total++; if (bus.dq_oe !== 1'b0) $display("FAIL reset_oe got %b exp 0", bus.dq_oe); else n_pass++;
      n_total++; if (bus.stb !== 1'b0) $display("FAIL reset_stb got %b exp 0", bus.stb); else n_pass++;
      n_total++; if (bus.dq_out !== 16'h0) $display("FAIL reset_dq got %h exp 0000", bus.dq_out); else n_pass++;
      n_total++; if (bus.dbg_state !== ST_IDLE) $display("FAIL reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE); else n_pass++;
`ifdef SDRAM_CAS_RSP_ERR_EN
      n_total++; if (err !== 1'b0 || err_cnt !== 8'd0) $display("FAIL reset_err got err=%b cnt=%0d exp 0/0", err, err_cnt); else n_pass++;
`endif
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_write_read_cl2();
      logic        exp_oe;
      logic [15:0] exp_d;
      cfg_sdr_cas = 3'd2;
      drv_cmd(C_WR, 8'h10, 16'hA000);
      step();
      n_total++; if (bus.dbg_state !== ST_WR_BURST) $display("FAIL wr_state got %0d exp %0d", bus.dbg_state, ST_WR_BURST); else n_pass++;
      for (int i = 1; i < BURST_LEN; i++) begin
         drv_cmd(C_NOP, 8'h00, 16'hA000 + 16'(i));
         step();
      end
      idle(3);
      n_total++; if (bus.dbg_state !== ST_IDLE) $display("FAIL wr_end_state got %0d exp %0d", bus.dbg_state, ST_IDLE); else n_pass++;
      drv_cmd(C_RD, 8'h10, 16'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 2) && (k <= 5);
         exp_d  = 16'hA000 + 16'(k - 2);
         n_total++; if (bus.dq_oe !== exp_oe || bus.stb !== exp_oe) $display("FAIL cl2_oe k=%0d got oe=%b stb=%b exp %b", k, bus.dq_oe, bus.stb, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL cl2_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
      end
      idle(3);
   endtask

   task automatic test_wrap_cl3();
      logic        exp_oe;
      logic [15:0] exp_d;
      cfg_sdr_cas = 3'd3;
      drv_cmd(C_RD, 8'h12, 16'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 3) && (k <= 6);
         exp_d  = 16'hA000 + 16'((k - 1) % 4);   // beats 2,3,0,1
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL wrap_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL wrap_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
      end
      idle(3);
   endtask

   task automatic test_back_to_back();
      logic        exp_oe;
      logic [15:0] exp_d;
      write_burst(8'h20, 16'hB000);
      idle(2);
      cfg_sdr_cas = 3'd2;
      drv_cmd(C_RD, 8'h10, 16'h0);
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 1) drv_cmd(C_RD, 8'h20, 16'h0);
         else        drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 2) && (k <= 7);
         exp_d  = (k < 4) ? 16'hA000 + 16'(k - 2) : 16'hB000 + 16'(k - 4);
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL b2b_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL b2b_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
      end
      idle(3);
   endtask

   task automatic test_write_after_read();
      cfg_sdr_cas = 3'd3;
      drv_cmd(C_RD, 8'h10, 16'h0);
      for (int k = 0; k < 9; k++) begin
         step();
         if (k == 0)     drv_cmd(C_WR, 8'h30, 16'hC000);
         else if (k < 4) drv_cmd(C_NOP, 8'h00, 16'hC000 + 16'(k));
         else            drv_cmd(C_NOP, 8'h00, 16'h0);
         n_total++; if (bus.dq_oe !== 1'b0) $display("FAIL war_oe k=%0d got %b exp 0", k, bus.dq_oe); else n_pass++;
`ifdef SDRAM_CAS_RSP_ERR_EN
         n_total++; if (err !== (k == 1)) $display("FAIL war_err k=%0d got %b exp %b", k, err, (k == 1)); else n_pass++;
`endif
      end
`ifdef SDRAM_CAS_RSP_ERR_EN
      n_total++; if (err_cnt !== 8'd1) $display("FAIL war_err_cnt got %0d exp 1", err_cnt); else n_pass++;
`endif
      idle(2);
   endtask

   task automatic test_illegal_cl();
      logic        exp_oe;
      logic [15:0] exp_d;
      do_reset();
      cfg_sdr_cas = 3'd5;
      drv_cmd(C_RD, 8'h30, 16'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 3) && (k <= 6);
         exp_d  = 16'hC000 + 16'(k - 3);
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL badcl_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL badcl_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
`ifdef SDRAM_CAS_RSP_ERR_EN
         n_total++; if (err !== (k == 0)) $display("FAIL badcl_err k=%0d got %b exp %b", k, err, (k == 0)); else n_pass++;
         n_total++; if (err_cnt !== 8'd1) $display("FAIL badcl_cnt k=%0d got %0d exp 1", k, err_cnt); else n_pass++;
`endif
      end
      idle(3);
   endtask

   task automatic test_cl1_and_cl_change();
      logic        exp_oe;
      logic [15:0] exp_d;
      cfg_sdr_cas = 3'd1;
      drv_cmd(C_RD, 8'h30, 16'h0);
      for (int k = 0; k < 6; k++) begin
         step();
         if (k == 0) drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 1) && (k <= 4);
         exp_d  = 16'hC000 + 16'(k - 1);
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL cl1_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL cl1_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
      end
      idle(3);
      cfg_sdr_cas = 3'd3;
      drv_cmd(C_RD, 8'h10, 16'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) begin
            cfg_sdr_cas = 3'd1;
            drv_cmd(C_RD, 8'h20, 16'h0);
         end else begin
            drv_cmd(C_NOP, 8'h00, 16'h0);
         end
         exp_oe = (k >= 2) && (k <= 5);
         exp_d  = 16'hB000 + 16'(k - 2);
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL clchg_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (exp_oe) begin
            n_total++; if (bus.dq_out !== exp_d) $display("FAIL clchg_data k=%0d got %h exp %h", k, bus.dq_out, exp_d); else n_pass++;
         end
`ifdef SDRAM_CAS_RSP_ERR_EN
         n_total++; if (err !== (k == 1)) $display("FAIL clchg_err k=%0d got %b exp %b", k, err, (k == 1)); else n_pass++;
`endif
      end
`ifdef SDRAM_CAS_RSP_ERR_EN
      n_total++; if (err_cnt !== 8'd2) $display("FAIL clchg_cnt got %0d exp 2", err_cnt); else n_pass++;
`endif
      idle(3);
   endtask

   task automatic test_reset_mid_burst();
      logic        exp_oe;
      cfg_sdr_cas = 3'd2;
      drv_cmd(C_RD, 8'h10, 16'h0);
      step();
      drv_cmd(C_NOP, 8'h00, 16'h0);
      step();
      step();
      n_total++; if (bus.dq_oe !== 1'b1 || bus.dq_out !== 16'hA000) $display("FAIL rst_pre got oe=%b dq=%h exp 1/a000", bus.dq_oe, bus.dq_out); else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_total++; if (bus.dq_oe !== 1'b0 || bus.stb !== 1'b0) $display("FAIL rst_async got oe=%b stb=%b exp 0/0", bus.dq_oe, bus.stb); else n_pass++;
      n_total++; if (bus.dq_out !== 16'h0) $display("FAIL rst_async_dq got %h exp 0000", bus.dq_out); else n_pass++;
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         n_total++; if (bus.dq_oe !== 1'b0 || bus.dbg_state !== ST_IDLE) $display("FAIL rst_idle k=%0d got oe=%b st=%0d exp 0/%0d", k, bus.dq_oe, bus.dbg_state, ST_IDLE); else n_pass++;
      end
`ifdef SDRAM_CAS_RSP_ERR_EN
      n_total++; if (err_cnt !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", err_cnt); else n_pass++;
`endif
      drv_cmd(C_RD, 8'h12, 16'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0) drv_cmd(C_NOP, 8'h00, 16'h0);
         exp_oe = (k >= 2);
         n_total++; if (bus.dq_oe !== exp_oe) $display("FAIL rst_after_oe k=%0d got %b exp %b", k, bus.dq_oe, exp_oe); else n_pass++;
         if (k == 2) begin
            n_total++; if (bus.dq_out !== 16'hA002) $display("FAIL rst_after_data got %h exp a002", bus.dq_out); else n_pass++;
         end
      end
      idle(4);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      drv_cmd(C_NOP, 8'h00, 16'h0);
      test_reset();
      test_write_read_cl2();
      test_wrap_cl3();
      test_back_to_back();
      test_write_after_read();
      test_illegal_cl();
      test_cl1_and_cl_change();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
